pipe_wb_stage: RTL and testbench
================================

Name: pipe_wb_stage

Overview:
- Parametrised, elastic successor to the fixed MEM/WB pipeline register.
- Carries the writeback bundle from memory stage to writeback stage: register-write enable, memory-to-register select, memory read data, ALU result, destination register.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, bubble gating of the write enable, and a saturating stall counter.

Parameters:
- DATA_W, 32, width of the memory data and ALU result fields.
- RN_W, 5, width of the destination register number.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held and incoming entries.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- mwreg  in  1  register-write enable.
- mm2reg  in  1  writeback select: 1 = memory data, 0 = ALU result.
- mmo  in  DATA_W  memory read data.
- malu  in  DATA_W  ALU result.
- mrn  in  RN_W  destination register number.
- out_valid  out  1  head bundle valid.
- out_ready  in  1  downstream accepts the head bundle.
- wwreg  out  1  register-write enable, gated by out_valid.
- wm2reg  out  1  head writeback select.
- wmo  out  DATA_W  head memory data.
- walu  out  DATA_W  head ALU result.
- wrn  out  RN_W  head destination register.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main register drives the outputs; skid register holds one extra entry. Each has its own valid bit.
- Reset (asynchronous, while reset=1):
  - Both valid bits, all fields, occupancy and stall_cnt clear to 0.
  - in_ready=1; all outputs 0.
  - Reset asserted mid-transfer drops all entries.
- in_ready = NOT skid_valid. It is registered state, with no combinational path from out_ready.
- Accept occurs when in_valid AND in_ready. Pop occurs when out_valid AND out_ready.
- Next-state priority per rising edge (reset excluded):
  1. flush=1: main_valid=0, skid_valid=0; any incoming bundle is discarded even if accepted. Field contents may be left unchanged.
  2. Main empty, or pop:
     - main loads the skid contents if skid_valid (skid becomes empty and takes the accept if one occurs);
     - otherwise main loads the accepted input;
     - otherwise main_valid=0.
  3. Main full and no pop: an accepted input loads skid (skid_valid=1).
- Latency: 1 cycle from accept to out_valid when the stage is empty. Full throughput: 1 bundle per cycle with out_ready held high.
- Ordering: FIFO order is preserved; skid contents always leave before the next input.
- Full condition: occupancy=2 forces in_ready=0. No accept is possible, so no overflow.
- Empty condition: out_valid=0 and wwreg=0.
- Fields hold their value when the stage is not loading.
- wwreg = main_wreg AND main_valid, so a bubble never writes the register file.
- occupancy = main_valid + skid_valid.
- stall_cnt:
  - increments when out_valid=1 and out_ready=0;
  - saturates at 2^CNT_W-1;
  - cleared only by reset; flush does not clear it.

Optional Feature:
- Macro: PIPE_WB_WDATA_EN.
- Defined: adds output port wdata, width DATA_W. wdata = wm2reg ? wmo : walu (combinational from the main register); wdata is 0 when out_valid=0.
- Not defined: the wdata port is absent; the writeback mux lives in the consumer.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release with no stimulus -> all outputs 0, in_ready=1, occupancy=0, stall_cnt=0.
- Single transfer: in_valid=1 for 1 cycle with mwreg=1, mm2reg=0, malu=0x0000_1234, mrn=5, out_ready=1 -> next cycle out_valid=1, wwreg=1, walu=0x1234, wrn=5; the cycle after, out_valid=0, wwreg=0.
- Back-pressure and skid: out_ready=0, push A (mrn=1), then B (mrn=2) -> occupancy=2, in_ready=0, C held off. Raise out_ready -> A, B, C (mrn=3) pop in consecutive cycles in order. stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush: 2 entries held, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, wwreg=0, in_ready=1, and the incoming bundle never appears.
- Async reset mid-stream: reset asserted between clock edges while occupancy=2 -> outputs clear immediately without a clock edge. stall_cnt is 0 after release.
- With PIPE_WB_WDATA_EN (CNT_W=2): mm2reg=1, mmo=0xDEAD_BEEF, malu=0x1 -> wdata=0xDEADBEEF. Hold out_ready=0 for 5 cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_wb_stage_if.sv
// Memory-to-writeback bundle interface for pipe_wb_stage.
// Carries wdata only when PIPE_WB_WDATA_EN is defined.
interface pipe_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RN_W   = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              mwreg;
  logic              mm2reg;
  logic [DATA_W-1:0] mmo;
  logic [DATA_W-1:0] malu;
  logic [RN_W-1:0]   mrn;
  logic              out_valid;
  logic              out_ready;
  logic              wwreg;
  logic              wm2reg;
  logic [DATA_W-1:0] wmo;
  logic [DATA_W-1:0] walu;
  logic [RN_W-1:0]   wrn;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
`ifdef PIPE_WB_WDATA_EN
  logic [DATA_W-1:0] wdata;

  modport master (
    output flush, in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
    input  in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn, occupancy, stall_cnt, wdata
  );
  modport slave (
    input  flush, in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
    output in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn, occupancy, stall_cnt, wdata
  );
`else
  modport master (
    output flush, in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
    input  in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn, occupancy, stall_cnt
  );
  modport slave (
    input  flush, in_valid, mwreg, mm2reg, mmo, malu, mrn, out_ready,
    output in_ready, out_valid, wwreg, wm2reg, wmo, walu, wrn, occupancy, stall_cnt
  );
`endif
endinterface

// File: rtl/pipe_wb_stage.sv
// Elastic MEM/WB pipeline register: 2-entry skid buffer, flush, bubble gating, stall counter.
// Optional writeback mux output wdata when PIPE_WB_WDATA_EN is defined.
module pipe_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RN_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clock,
  input logic              reset,
  pipe_wb_stage_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_main_v, r_skid_v, r_in_ready, r_wwreg;
  logic [1:0]        r_occ;
  logic [CNT_W-1:0]  r_stall;
  logic              r_main_wreg, r_main_m2reg, r_skid_wreg, r_skid_m2reg;
  logic [DATA_W-1:0] r_main_mo, r_main_alu, r_skid_mo, r_skid_alu;
  logic [RN_W-1:0]   r_main_rn, r_skid_rn;

  logic              w_accept, w_pop;
  logic              w_main_v_n, w_skid_v_n;
  logic [CNT_W-1:0]  w_stall_n;
  logic              w_main_wreg_n, w_main_m2reg_n, w_skid_wreg_n, w_skid_m2reg_n;
  logic [DATA_W-1:0] w_main_mo_n, w_main_alu_n, w_skid_mo_n, w_skid_alu_n;
  logic [RN_W-1:0]   w_main_rn_n, w_skid_rn_n;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = r_main_v & bus.out_ready;

  // Next-state: flush beats refill from skid, which beats loading the input.
  always_comb begin
    w_main_v_n     = r_main_v;
    w_skid_v_n     = r_skid_v;
    w_main_wreg_n  = r_main_wreg;
    w_main_m2reg_n = r_main_m2reg;
    w_main_mo_n    = r_main_mo;
    w_main_alu_n   = r_main_alu;
    w_main_rn_n    = r_main_rn;
    w_skid_wreg_n  = r_skid_wreg;
    w_skid_m2reg_n = r_skid_m2reg;
    w_skid_mo_n    = r_skid_mo;
    w_skid_alu_n   = r_skid_alu;
    w_skid_rn_n    = r_skid_rn;
    w_stall_n      = r_stall;

    if (r_main_v && !bus.out_ready && (r_stall != CNT_MAX)) begin
      w_stall_n = r_stall + CNT_W'(1);
    end

    if (bus.flush) begin
      w_main_v_n = 1'b0;
      w_skid_v_n = 1'b0;
    end else if (!r_main_v || w_pop) begin
      if (r_skid_v) begin
        w_main_v_n     = 1'b1;
        w_main_wreg_n  = r_skid_wreg;
        w_main_m2reg_n = r_skid_m2reg;
        w_main_mo_n    = r_skid_mo;
        w_main_alu_n   = r_skid_alu;
        w_main_rn_n    = r_skid_rn;
        w_skid_v_n     = w_accept;
        if (w_accept) begin
          w_skid_wreg_n  = bus.mwreg;
          w_skid_m2reg_n = bus.mm2reg;
          w_skid_mo_n    = bus.mmo;
          w_skid_alu_n   = bus.malu;
          w_skid_rn_n    = bus.mrn;
        end
      end else if (w_accept) begin
        w_main_v_n     = 1'b1;
        w_main_wreg_n  = bus.mwreg;
        w_main_m2reg_n = bus.mm2reg;
        w_main_mo_n    = bus.mmo;
        w_main_alu_n   = bus.malu;
        w_main_rn_n    = bus.mrn;
      end else begin
        w_main_v_n = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_v_n     = 1'b1;
      w_skid_wreg_n  = bus.mwreg;
      w_skid_m2reg_n = bus.mm2reg;
      w_skid_mo_n    = bus.mmo;
      w_skid_alu_n   = bus.malu;
      w_skid_rn_n    = bus.mrn;
    end
  end

  // Derived outputs are registered from next-state so none depend on out_ready combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_v     <= 1'b0;
      r_skid_v     <= 1'b0;
      r_in_ready   <= 1'b1;
      r_wwreg      <= 1'b0;
      r_occ        <= 2'd0;
      r_stall      <= '0;
      r_main_wreg  <= 1'b0;
      r_main_m2reg <= 1'b0;
      r_main_mo    <= '0;
      r_main_alu   <= '0;
      r_main_rn    <= '0;
      r_skid_wreg  <= 1'b0;
      r_skid_m2reg <= 1'b0;
      r_skid_mo    <= '0;
      r_skid_alu   <= '0;
      r_skid_rn    <= '0;
    end else begin
      r_main_v     <= w_main_v_n;
      r_skid_v     <= w_skid_v_n;
      r_in_ready   <= ~w_skid_v_n;
      r_wwreg      <= w_main_v_n & w_main_wreg_n;
      r_occ        <= 2'(w_main_v_n) + 2'(w_skid_v_n);
      r_stall      <= w_stall_n;
      r_main_wreg  <= w_main_wreg_n;
      r_main_m2reg <= w_main_m2reg_n;
      r_main_mo    <= w_main_mo_n;
      r_main_alu   <= w_main_alu_n;
      r_main_rn    <= w_main_rn_n;
      r_skid_wreg  <= w_skid_wreg_n;
      r_skid_m2reg <= w_skid_m2reg_n;
      r_skid_mo    <= w_skid_mo_n;
      r_skid_alu   <= w_skid_alu_n;
      r_skid_rn    <= w_skid_rn_n;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_v;
  assign bus.wwreg     = r_wwreg;
  assign bus.wm2reg    = r_main_m2reg;
  assign bus.wmo       = r_main_mo;
  assign bus.walu      = r_main_alu;
  assign bus.wrn       = r_main_rn;
  assign bus.occupancy = r_occ;
  assign bus.stall_cnt = r_stall;

`ifdef PIPE_WB_WDATA_EN
  logic [DATA_W-1:0] r_wdata;

  // Writeback mux result for the head bundle, zero while the stage is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdata <= '0;
    end else begin
      r_wdata <= w_main_v_n ? (w_main_m2reg_n ? w_main_mo_n : w_main_alu_n) : '0;
    end
  end

  assign bus.wdata = r_wdata;
`endif
endmodule

// File: tb/tb_pipe_wb_stage.sv
// Testbench for pipe_wb_stage: directed vector table, corner sequences, random vs queue model.
module tb_pipe_wb_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RN_W   = 5;
`ifdef PIPE_WB_WDATA_EN
  localparam int unsigned CNT_W  = 2;
`else
  localparam int unsigned CNT_W  = 16;
`endif
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_wb_stage_if #(.DATA_W(DATA_W), .RN_W(RN_W), .CNT_W(CNT_W)) bus ();
  pipe_wb_stage #(.DATA_W(DATA_W), .RN_W(RN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit fl; bit iv; bit ordy; bit wr;
    logic [31:0] alu; logic [4:0] rn;
    bit ov; bit ww; int occ; bit ir; int st;
    logic [4:0] ern; logic [31:0] ealu;
  } vec_t;

  typedef struct {
    bit wreg; bit m2reg;
    logic [DATA_W-1:0] mo; logic [DATA_W-1:0] alu; logic [RN_W-1:0] rn;
  } bundle_t;

  int n_pass  = 0;
  int n_total = 0;
  bundle_t q[$];
  longint unsigned mstall;
  vec_t tv[15];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input bit fl, input bit iv, input bit ordy, input bit wr, input bit m2r,
                       input logic [31:0] mo, input logic [31:0] alu, input logic [4:0] rn);
    bus.flush = fl; bus.in_valid = iv; bus.out_ready = ordy; bus.mwreg = wr;
    bus.mm2reg = m2r; bus.mmo = mo; bus.malu = alu; bus.mrn = rn;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    q.delete();
    mstall = 0;
  endtask

  function automatic longint unsigned sat(input longint unsigned v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Queue-level model: pop head if downstream takes it, append input if fewer than two held.
  task automatic model_edge();
    bit pop, acc;
    bundle_t b;
    acc = bus.in_valid && (q.size() < 2);
    pop = (q.size() > 0) && bus.out_ready;
    if ((q.size() > 0) && !bus.out_ready) mstall = sat(mstall + 1);
    b.wreg = bus.mwreg; b.m2reg = bus.mm2reg; b.mo = bus.mmo; b.alu = bus.malu; b.rn = bus.mrn;
    if (bus.flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
    chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(q.size()));
    chk({tag, ".in_ready"},  64'(bus.in_ready),  64'(q.size() < 2));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), mstall);
    if (q.size() > 0) begin
      chk({tag, ".wwreg"},  64'(bus.wwreg),  64'(q[0].wreg));
      chk({tag, ".wm2reg"}, 64'(bus.wm2reg), 64'(q[0].m2reg));
      chk({tag, ".wmo"},    64'(bus.wmo),    64'(q[0].mo));
      chk({tag, ".walu"},   64'(bus.walu),   64'(q[0].alu));
      chk({tag, ".wrn"},    64'(bus.wrn),    64'(q[0].rn));
`ifdef PIPE_WB_WDATA_EN
      chk({tag, ".wdata"}, 64'(bus.wdata), 64'(q[0].m2reg ? q[0].mo : q[0].alu));
`endif
    end else begin
      chk({tag, ".wwreg"}, 64'(bus.wwreg), 64'd0);
`ifdef PIPE_WB_WDATA_EN
      chk({tag, ".wdata"}, 64'(bus.wdata), 64'd0);
`endif
    end
  endtask

  initial begin
    //        fl    iv    ordy  wr    alu       rn     ov    ww    occ ir   st  ern    ealu
    tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 0, 1'b1, 0, 5'd0, 32'h0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 5'd5, 1'b1, 1'b1, 1, 1'b1, 0, 5'd5, 32'h1234};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 0, 1'b1, 0, 5'd0, 32'h0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hA,    5'd1, 1'b1, 1'b1, 1, 1'b1, 0, 5'd1, 32'hA};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hB,    5'd2, 1'b1, 1'b1, 2, 1'b0, 1, 5'd1, 32'hA};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hC,    5'd3, 1'b1, 1'b1, 2, 1'b0, 2, 5'd1, 32'hA};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC,    5'd3, 1'b1, 1'b0, 1, 1'b1, 2, 5'd2, 32'hB};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC,    5'd3, 1'b1, 1'b1, 1, 1'b1, 2, 5'd3, 32'hC};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 0, 1'b1, 2, 5'd0, 32'h0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hD,    5'd6, 1'b1, 1'b1, 1, 1'b1, 2, 5'd6, 32'hD};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hE,    5'd7, 1'b1, 1'b1, 2, 1'b0, 3, 5'd6, 32'hD};
    tv[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hF,    5'd8, 1'b0, 1'b0, 0, 1'b1, 4, 5'd0, 32'h0};
    tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 0, 1'b1, 4, 5'd0, 32'h0};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h9,    5'd9, 1'b0, 1'b0, 0, 1'b1, 4, 5'd0, 32'h0};
    tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    5'd0, 1'b0, 1'b0, 0, 1'b1, 4, 5'd0, 32'h0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    do_reset();
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.wwreg",     64'(bus.wwreg),     64'd0);
    chk("rst.wm2reg",    64'(bus.wm2reg),    64'd0);
    chk("rst.wmo",       64'(bus.wmo),       64'd0);
    chk("rst.walu",      64'(bus.walu),      64'd0);
    chk("rst.wrn",       64'(bus.wrn),       64'd0);
    chk("rst.occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst.stall_cnt", 64'(bus.stall_cnt), 64'd0);

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].fl, tv[i].iv, tv[i].ordy, tv[i].wr, 1'b0, 32'h0, tv[i].alu, tv[i].rn);
      step();
      chk($sformatf("tv%0d.out_valid", i), 64'(bus.out_valid), 64'(tv[i].ov));
      chk($sformatf("tv%0d.wwreg", i),     64'(bus.wwreg),     64'(tv[i].ww));
      chk($sformatf("tv%0d.occupancy", i), 64'(bus.occupancy), 64'(tv[i].occ));
      chk($sformatf("tv%0d.in_ready", i),  64'(bus.in_ready),  64'(tv[i].ir));
      chk($sformatf("tv%0d.stall_cnt", i), 64'(bus.stall_cnt), sat(64'(tv[i].st)));
      if (tv[i].ov) begin
        chk($sformatf("tv%0d.wrn", i),  64'(bus.wrn),  64'(tv[i].ern));
        chk($sformatf("tv%0d.walu", i), 64'(bus.walu), 64'(tv[i].ealu));
      end
    end

`ifdef PIPE_WB_WDATA_EN
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd4);
    step();
    chk("wd.mem", 64'(bus.wdata), 64'hDEAD_BEEF);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      step();
      chk($sformatf("wd.sat%0d", k), 64'(bus.stall_cnt), sat(64'(k)));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h99, 32'h55, 5'd3);
    step();
    chk("wd.alu", 64'(bus.wdata), 64'h55);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("wd.empty", 64'(bus.wdata), 64'd0);
`endif

    // Fill both entries, then assert reset between clock edges.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h11, 5'd1);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h22, 5'd2);
    step();
    step();
    chk("ar.pre_occ", 64'(bus.occupancy), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("ar.out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar.wwreg",     64'(bus.wwreg),     64'd0);
    chk("ar.occupancy", 64'(bus.occupancy), 64'd0);
    chk("ar.in_ready",  64'(bus.in_ready),  64'd1);
    chk("ar.walu",      64'(bus.walu),      64'd0);
    chk("ar.wrn",       64'(bus.wrn),       64'd0);
    chk("ar.stall_cnt", 64'(bus.stall_cnt), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    do_reset();
    step();
    chk("ar.post_stall", 64'(bus.stall_cnt), 64'd0);
    chk("ar.post_occ",   64'(bus.occupancy), 64'd0);

    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
            1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
      model_edge();
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
